// File: rtl/sbi_pkg.sv
// sbi_pkg: shared state encoding and SBI timing constants for the burst master.
package sbi_pkg;
  typedef enum logic [1:0] {IDLE, START, BURST, DRAIN} sbi_mst_state_e;
  localparam int SBI_RD_LAT = 1;
endpackage

// File: rtl/sbi_rd_fifo.sv
// sbi_rd_fifo: small read-data FIFO; push and pop may coincide, head reads as 0 when empty.
module sbi_rd_fifo #(
  parameter int Width = 32,
  parameter int RdDepth = 2,
  localparam int CntW = $clog2(RdDepth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = RdDepth > 1 ? $clog2(RdDepth) : 1;
  logic [Width-1:0] mem_q [RdDepth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(RdDepth - 1) ? '0 : p + 1'b1;
  endfunction

  assign count_o = count_q;
  assign full_o  = count_q == CntW'(RdDepth);
  assign empty_o = count_q == '0;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= nxt(wptr_q);
      if (pop_i) rptr_q <= nxt(rptr_q);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end
endmodule

// File: rtl/sbi_burst_master.sv
// sbi_burst_master: turns one burst command into an SBI start cycle plus per-beat accesses,
// streaming write data in and buffering read data out with credit-limited issue.
module sbi_burst_master
  import sbi_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 256,
  parameter int LenW = 8,
  parameter int RdDepth = 2,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             bCLK,
  input  logic             bRSTn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [Aw-1:0]    cmd_addr,
  input  logic [LenW-1:0]  cmd_len,
  output logic             cmd_done,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [Width-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [Width-1:0] rd_data,
  output logic [Aw-1:0]    bADDR,
  output logic             bSTART,
  output logic             bACCESS,
  output logic             bWRITE,
  output logic [Width-1:0] bD,
  input  logic [Width-1:0] bQ,
  input  logic             bVALID
);
  localparam int CntW = $clog2(RdDepth + 1);
  localparam int CrW = CntW + 1;
  sbi_mst_state_e        state_q;
  logic                  write_q;
  logic [Aw-1:0]         addr_q;
  logic [LenW-1:0]       len_q, issued_q, received_q;
  logic [SBI_RD_LAT-1:0] inflight_q;
  logic [CntW-1:0]       count;
  logic                  full, empty, pop, push, rd_issue, last_issue;

  sbi_rd_fifo #(.Width(Width), .RdDepth(RdDepth)) u_fifo (
    .clk_i(bCLK), .rst_ni(bRSTn), .push_i(push), .pop_i(pop), .wdata_i(bQ),
    .rdata_o(rd_data), .count_o(count), .full_o(full), .empty_o(empty)
  );

  assign cmd_ready  = state_q == IDLE;
  assign bSTART     = state_q == START;
  assign bADDR      = addr_q;
  assign bWRITE     = write_q;
  assign wr_ready   = state_q == BURST && write_q && wr_valid;
  assign bD         = wr_ready ? wr_data : '0;
  assign rd_valid   = !empty;
  assign pop        = rd_valid && rd_ready;
  assign push       = bVALID && (!full || pop);
  assign last_issue = issued_q == len_q;
  // Credit: occupancy plus reads still in flight must leave room for this beat's data.
  assign rd_issue   = state_q == BURST && !write_q &&
                      (CrW'(count) + CrW'($countones(inflight_q)) < CrW'(RdDepth) + CrW'(pop));
  assign bACCESS    = wr_ready || rd_issue;
  assign cmd_done   = (wr_ready && last_issue) || (state_q == DRAIN && push && received_q == len_q);

  always_ff @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      inflight_q <= '0;
    end else begin
      inflight_q <= SBI_RD_LAT'({inflight_q, rd_issue});
      if (push) received_q <= received_q + 1'b1;
      if (bACCESS) issued_q <= issued_q + 1'b1;
      case (state_q)
        IDLE: if (cmd_valid) begin
          state_q    <= START;
          write_q    <= cmd_write;
          addr_q     <= cmd_addr;
          len_q      <= cmd_len;
          issued_q   <= '0;
          received_q <= '0;
        end
        START: state_q <= BURST;
        BURST: if (bACCESS && last_issue) begin
          state_q <= write_q ? IDLE : DRAIN;
          write_q <= 1'b0;
        end
        DRAIN: if (cmd_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbi_burst_master.sv
// tb_sbi_burst_master: directed vector table for write bursts plus hand sequences for reads,
// back-to-back commands and mid-burst reset, against a one-cycle-latency SBI slave model.
module tb_sbi_burst_master;
  logic        bCLK, bRSTn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done;
  logic [7:0]  cmd_addr, cmd_len, bADDR;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_data, rd_data, bD, bQ;
  logic        bSTART, bACCESS, bWRITE, bVALID;
  int          checks = 0, errors = 0;

  sbi_burst_master dut (
    .bCLK(bCLK), .bRSTn(bRSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .bADDR(bADDR), .bSTART(bSTART),
    .bACCESS(bACCESS), .bWRITE(bWRITE), .bD(bD), .bQ(bQ), .bVALID(bVALID)
  );

  initial bCLK = 1'b0;
  always #5 bCLK = ~bCLK;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hD000_0000 | {24'h0, a};
  endfunction

  // Slave model: start latches the address, each access advances it, read data one cycle later.
  logic [31:0] mem [256];
  logic [7:0]  sptr;
  always @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      sptr   <= 8'h0;
      bVALID <= 1'b0;
      bQ     <= 32'h0;
    end else begin
      bVALID <= bACCESS && !bWRITE;
      if (bACCESS && !bWRITE) bQ <= mem[sptr];
      if (bACCESS && bWRITE) mem[sptr] <= bD;
      if (bSTART) sptr <= bADDR;
      else if (bACCESS) sptr <= sptr + 8'h1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_cmd_done"}, cmd_done, 0);
    chk({p, "_wr_ready"}, wr_ready, 0);
    chk({p, "_rd_valid"}, rd_valid, 0);
    chk({p, "_rd_data"}, rd_data, 0);
    chk({p, "_bADDR"}, bADDR, 0);
    chk({p, "_bSTART"}, bSTART, 0);
    chk({p, "_bACCESS"}, bACCESS, 0);
    chk({p, "_bWRITE"}, bWRITE, 0);
    chk({p, "_bD"}, bD, 0);
  endtask

  typedef struct {
    logic cv, cw; logic [7:0] addr, len; logic wv; logic [31:0] wd;
    logic rdy, st, acc, wr, wrdy, done; logic [31:0] bd; logic [7:0] badr;
  } vec_t;

  function automatic vec_t v(input logic cv, cw, input logic [7:0] addr, len, input logic wv,
                             input logic [31:0] wd, input logic rdy, st, acc, wr, wrdy, done,
                             input logic [31:0] bd, input logic [7:0] badr);
    vec_t r;
    r.cv = cv; r.cw = cw; r.addr = addr; r.len = len; r.wv = wv; r.wd = wd;
    r.rdy = rdy; r.st = st; r.acc = acc; r.wr = wr; r.wrdy = wrdy; r.done = done;
    r.bd = bd; r.badr = badr;
    return r;
  endfunction

  int          acc_q[$], start_q[$], done_q[$];
  logic [31:0] got_q[$];
  int          done_c, first_got, ovf;

  task automatic run_read(input logic [7:0] a, input logic [7:0] l, input int rel, input int maxc);
    int c, occ;
    acc_q.delete(); got_q.delete();
    done_c = -1; first_got = -1; ovf = 0; c = 0; occ = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
    while (c < maxc && !(done_c >= 0 && got_q.size() == int'(l) + 1)) begin
      rd_ready = c >= rel;
      @(negedge bCLK);
      if (c == 0) chk("rd_cmd_ready", cmd_ready, 1);
      if (bACCESS) acc_q.push_back(c);
      if (cmd_done) done_c = c;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        if (first_got < 0) first_got = c;
      end
      occ = occ + int'(bVALID) - int'(rd_valid && rd_ready);
      if (occ > 2) ovf++;
      @(posedge bCLK); #1;
      cmd_valid = 0;
      c++;
    end
    rd_ready = 0;
    chk("rd_timeout", c < maxc, 1);
    for (int k = 0; k <= int'(l); k++)
      chk($sformatf("rd_word%0d", k), k < got_q.size() ? got_q[k] : 32'hxxxx_xxxx, pat(a + 8'(k)));
  endtask

  vec_t tbl[18];

  initial begin
    bRSTn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    tbl[0]  = v(1, 1, 8'h10, 8'd3, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tbl[1]  = v(0, 0, 0, 0,        1, 'hA0,  0, 1, 0, 1, 0, 0, 0,     8'h10);
    tbl[2]  = v(0, 0, 0, 0,        1, 'hA0,  0, 0, 1, 1, 1, 0, 'hA0,  0);
    tbl[3]  = v(0, 0, 0, 0,        1, 'hA1,  0, 0, 1, 1, 1, 0, 'hA1,  0);
    tbl[4]  = v(0, 0, 0, 0,        1, 'hA2,  0, 0, 1, 1, 1, 0, 'hA2,  0);
    tbl[5]  = v(0, 0, 0, 0,        1, 'hA3,  0, 0, 1, 1, 1, 1, 'hA3,  0);
    tbl[6]  = v(0, 0, 0, 0,        0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tbl[7]  = v(1, 1, 8'h20, 8'd3, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tbl[8]  = v(0, 0, 0, 0,        0, 'hB0,  0, 1, 0, 1, 0, 0, 0,     8'h20);
    tbl[9]  = v(0, 0, 0, 0,        0, 'hB0,  0, 0, 0, 1, 0, 0, 0,     0);
    tbl[10] = v(0, 0, 0, 0,        1, 'hB0,  0, 0, 1, 1, 1, 0, 'hB0,  0);
    tbl[11] = v(0, 0, 0, 0,        0, 'hB1,  0, 0, 0, 1, 0, 0, 0,     0);
    tbl[12] = v(0, 0, 0, 0,        1, 'hB1,  0, 0, 1, 1, 1, 0, 'hB1,  0);
    tbl[13] = v(0, 0, 0, 0,        0, 'hB2,  0, 0, 0, 1, 0, 0, 0,     0);
    tbl[14] = v(0, 0, 0, 0,        1, 'hB2,  0, 0, 1, 1, 1, 0, 'hB2,  0);
    tbl[15] = v(0, 0, 0, 0,        0, 'hB3,  0, 0, 0, 1, 0, 0, 0,     0);
    tbl[16] = v(0, 0, 0, 0,        1, 'hB3,  0, 0, 1, 1, 1, 1, 'hB3,  0);
    tbl[17] = v(0, 0, 0, 0,        0, 0,     1, 0, 0, 0, 0, 0, 0,     0);

    repeat (2) @(posedge bCLK);
    @(negedge bCLK);
    check_reset("init");
    bRSTn = 1;
    @(posedge bCLK); #1;

    for (int i = 0; i < 18; i++) begin
      cmd_valid = tbl[i].cv; cmd_write = tbl[i].cw; cmd_addr = tbl[i].addr; cmd_len = tbl[i].len;
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      @(negedge bCLK);
      chk($sformatf("w%0d_cmd_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("w%0d_bSTART", i), bSTART, tbl[i].st);
      chk($sformatf("w%0d_bACCESS", i), bACCESS, tbl[i].acc);
      chk($sformatf("w%0d_bWRITE", i), bWRITE, tbl[i].wr);
      chk($sformatf("w%0d_wr_ready", i), wr_ready, tbl[i].wrdy);
      chk($sformatf("w%0d_cmd_done", i), cmd_done, tbl[i].done);
      if (tbl[i].acc) chk($sformatf("w%0d_bD", i), bD, tbl[i].bd);
      if (tbl[i].st) chk($sformatf("w%0d_bADDR", i), bADDR, tbl[i].badr);
      @(posedge bCLK); #1;
    end
    cmd_valid = 0; wr_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wmem_10_%0d", k), mem[8'h10 + k], 32'hA0 + k);
      chk($sformatf("wmem_20_%0d", k), mem[8'h20 + k], 32'hB0 + k);
    end

    run_read(8'hFE, 8'd3, 0, 30);
    chk("r1_acc_count", acc_q.size(), 4);
    chk("r1_first_acc", acc_q.size() > 0 ? acc_q[0] : -1, 2);
    chk("r1_last_acc", acc_q.size() > 3 ? acc_q[3] : -1, 5);
    chk("r1_done_cycle", done_c, 6);
    chk("r1_first_data", first_got, 4);

    run_read(8'h40, 8'd7, 12, 80);
    begin
      int early = 0;
      foreach (acc_q[k]) if (acc_q[k] < 12) early++;
      chk("r2_acc_before_release", early, 2);
    end
    chk("r2_acc_total", acc_q.size(), 8);
    chk("r2_done_seen", done_c >= 12, 1);
    chk("r2_no_overflow", ovf, 0);

    start_q.delete(); done_q.delete();
    rd_ready = 0; cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h50; cmd_len = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) begin
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h60; cmd_len = 0; wr_valid = 1; wr_data = 32'hCC;
      end
      @(negedge bCLK);
      if (c == 4) chk("b2b_cmd_ready", cmd_ready, 1);
      if (bSTART) start_q.push_back(c);
      if (cmd_done) done_q.push_back(c);
      @(posedge bCLK); #1;
      cmd_valid = 0;
    end
    wr_valid = 0;
    chk("b2b_start_count", start_q.size(), 2);
    chk("b2b_start_gap", start_q.size() == 2 && start_q[1] - start_q[0] >= 2, 1);
    chk("b2b_done_count", done_q.size(), 2);
    chk("b2b_rd_valid", rd_valid, 1);
    chk("b2b_rd_data", rd_data, pat(8'h50));
    chk("b2b_wmem", mem[8'h60], 32'hCC);
    rd_ready = 1;
    @(posedge bCLK); #1;
    rd_ready = 0;
    chk("b2b_rd_drained", rd_valid, 0);

    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h80; cmd_len = 8'd7;
    repeat (4) begin
      @(posedge bCLK); #1;
      cmd_valid = 0;
    end
    chk("rst_pre_rd_valid", rd_valid, 1);
    #2 bRSTn = 0;
    #1 check_reset("mid");
    @(negedge bCLK);
    @(posedge bCLK);
    @(negedge bCLK);
    bRSTn = 1;
    @(posedge bCLK); #1;
    chk("rst_post_cmd_ready", cmd_ready, 1);
    chk("rst_post_rd_valid", rd_valid, 0);
    run_read(8'h05, 8'd0, 0, 20);
    chk("rst_post_done", done_c >= 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
